// File: rtl/if_queue.sv
// Instruction fetch queue: circular FIFO of {pc, instr, excp} between fetch and decode.
// Optional fetch back-pressure statistics counter enabled by defining IFQ_STATS_EN.
module if_queue #(
   parameter int unsigned            PC_WIDTH    = 32,
   parameter int unsigned            INSTR_WIDTH = 32,
   parameter int unsigned            DEPTH       = 4,
   parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = INSTR_WIDTH'(32'h00000013)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush_i,
   input  logic                     fetch_valid_i,
   output logic                     fetch_ready_o,
   input  logic [PC_WIDTH-1:0]      fetch_pc_i,
   input  logic [INSTR_WIDTH-1:0]   fetch_instr_i,
   input  logic [1:0]               fetch_excp_i,
   output logic                     id_valid_o,
   input  logic                     id_ready_i,
   output logic [PC_WIDTH-1:0]      id_pc_o,
   output logic [INSTR_WIDTH-1:0]   id_instr_o,
   output logic [1:0]               id_excp_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic [31:0]              stall_cnt_o
);

   localparam int unsigned    AW       = $clog2(DEPTH);
   localparam int unsigned    EW       = PC_WIDTH + INSTR_WIDTH + 2;
   localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

   logic [EW-1:0]   mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     count_q, count_d;
   logic            enq, deq;
   logic [EW-1:0]   head;

   always_comb begin
      fetch_ready_o = (count_q != FULL_CNT) && !flush_i;
      id_valid_o    = (count_q != '0) && !flush_i;
      enq           = fetch_valid_i && fetch_ready_o;
      deq           = id_valid_o && id_ready_i;
      head          = mem_q[rd_ptr_q];

      if (id_valid_o) begin
         id_pc_o    = head[EW-1 -: PC_WIDTH];
         id_instr_o = head[INSTR_WIDTH+1 -: INSTR_WIDTH];
         id_excp_o  = head[1:0];
      end else begin
         id_pc_o    = '0;
         id_instr_o = NOP_INSTR;
         id_excp_o  = '0;
      end

      // A redirect discards everything; masked handshakes mean enq/deq are already 0.
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         wr_ptr_d = wr_ptr_q + AW'(enq);
         rd_ptr_d = rd_ptr_q + AW'(deq);
         count_d  = count_q + (AW+1)'(enq) - (AW+1)'(deq);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && enq) begin
         mem_q[wr_ptr_q] <= {fetch_pc_i, fetch_instr_i, fetch_excp_i};
      end
   end

   assign count_o = count_q;

`ifdef IFQ_STATS_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (fetch_valid_i && !fetch_ready_o && !flush_i && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   // Survives flush on purpose: it measures back-pressure across redirects.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
`else
   assign stall_cnt_o = 32'h0;
`endif

endmodule
